// File: rtl/mips_defs.sv
// Shared MIPS core definitions: reset vector, NOP word and jump-select encodings.
package mips_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'd0,
    JUMP_IMM  = 2'd1,
    JUMP_REG  = 2'd2,
    JUMP_RSVD = 2'd3
  } jump_op_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target mux: register jump > immediate jump > branch > sequential.
module npc_calc
  import mips_defs::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] id_pc,
  input  logic            branch,
  input  jump_op_e        jump_op,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic [XLEN-1:0] rs_value,
  output logic [XLEN-1:0] seq_pc,
  output logic [XLEN-1:0] target,
  output logic            take
);

  logic [XLEN-1:0] id_pc_plus4;
  logic [XLEN-1:0] branch_off;

  always_comb begin
    seq_pc      = pc + 32'd4;
    id_pc_plus4 = id_pc + 32'd4;
    branch_off  = {{14{imm16[15]}}, imm16, 2'b00};
    target      = seq_pc;
    take        = 1'b0;
    // reserved encoding falls through to the branch/sequential path
    case (jump_op)
      JUMP_REG: begin
        target = rs_value;
        take   = 1'b1;
      end
      JUMP_IMM: begin
        target = {id_pc_plus4[31:28], imm26, 2'b00};
        take   = 1'b1;
      end
      default: begin
        if (branch) begin
          target = id_pc_plus4 + branch_off;
          take   = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and IF/ID pipeline register with stall and delay-slot redirect.
module fetch_pc_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [1:0]  jump_op,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_value,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        id_adel,
  output logic        redirect
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target;
  logic            take;
  logic [XLEN-1:0] next_pc;

  npc_calc u_npc_calc (
    .pc       (pc),
    .id_pc    (id_pc),
    .branch   (branch),
    .jump_op  (jump_op_e'(jump_op)),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_value (rs_value),
    .seq_pc   (seq_pc),
    .target   (target),
    .take     (take)
  );

  // decisions on the reset bubble or during a stall are dropped
  always_comb begin
    redirect = take & ~stall & id_valid;
    next_pc  = redirect ? target : seq_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      id_pc    <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (!stall) begin
      pc       <= next_pc;
      id_pc    <= pc;
      id_instr <= im_instr;
      id_valid <= 1'b1;
      id_adel  <= |pc[1:0];
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit plus a reset-during-stall sequence.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [1:0]  jump_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_value;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_adel;
  logic        redirect;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_pc_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .branch   (branch),
    .jump_op  (jump_op),
    .imm16    (imm16),
    .imm26    (imm26),
    .rs_value (rs_value),
    .im_instr (im_instr),
    .pc       (pc),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_valid (id_valid),
    .id_adel  (id_adel),
    .redirect (redirect)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        branch;
    logic [1:0]  jop;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs;
    logic [31:0] im;
    logic        e_redir;
    logic [31:0] e_pc;
    logic [31:0] e_id_pc;
    logic [31:0] e_id_instr;
    logic        e_valid;
    logic        e_adel;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; jump_op = 2'd0; imm16 = 16'h0; imm26 = 26'h0;
    rs_value = 32'h0; im_instr = 32'h0;
  endtask

  initial begin
    //          rst st br jop imm16     imm26        rs            im             redir pc            id_pc         id_instr      v  adel
    vecs[0]  = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0000, 0, 32'h0000_3004, 32'h0000_3000, 32'hC0DE_0000, 1, 0};
    vecs[1]  = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0001, 0, 32'h0000_3008, 32'h0000_3004, 32'hC0DE_0001, 1, 0};
    vecs[2]  = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0002, 0, 32'h0000_300C, 32'h0000_3008, 32'hC0DE_0002, 1, 0};
    vecs[3]  = '{1, 0, 1, 2'd0, 16'h0010, 26'h0000000, 32'h0,        32'hC0DE_0003, 0, 32'h0000_3004, 32'h0000_3000, 32'hC0DE_0003, 1, 0};
    vecs[4]  = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0004, 0, 32'h0000_3008, 32'h0000_3004, 32'hC0DE_0004, 1, 0};
    vecs[5]  = '{0, 0, 1, 2'd0, 16'hFFFF, 26'h0000000, 32'h0,        32'hC0DE_0005, 1, 32'h0000_3004, 32'h0000_3008, 32'hC0DE_0005, 1, 0};
    vecs[6]  = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0006, 0, 32'h0000_3008, 32'h0000_3004, 32'hC0DE_0006, 1, 0};
    vecs[7]  = '{0, 0, 1, 2'd2, 16'h0040, 26'h0000000, 32'h0000_3010, 32'hC0DE_0007, 1, 32'h0000_3010, 32'h0000_3008, 32'hC0DE_0007, 1, 0};
    vecs[8]  = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0008, 0, 32'h0000_3014, 32'h0000_3010, 32'hC0DE_0008, 1, 0};
    vecs[9]  = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0009, 0, 32'h0000_3018, 32'h0000_3014, 32'hC0DE_0009, 1, 0};
    vecs[10] = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_000A, 0, 32'h0000_301C, 32'h0000_3018, 32'hC0DE_000A, 1, 0};
    vecs[11] = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_000B, 0, 32'h0000_3020, 32'h0000_301C, 32'hC0DE_000B, 1, 0};
    vecs[12] = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_000C, 0, 32'h0000_3024, 32'h0000_3020, 32'hC0DE_000C, 1, 0};
    vecs[13] = '{0, 0, 1, 2'd1, 16'h0100, 26'h0000C10, 32'h0,        32'hC0DE_000D, 1, 32'h0000_3040, 32'h0000_3024, 32'hC0DE_000D, 1, 0};
    vecs[14] = '{0, 1, 1, 2'd0, 16'h0004, 26'h0000000, 32'h0,        32'hC0DE_000E, 0, 32'h0000_3040, 32'h0000_3024, 32'hC0DE_000D, 1, 0};
    vecs[15] = '{0, 1, 1, 2'd0, 16'h0004, 26'h0000000, 32'h0,        32'hC0DE_000F, 0, 32'h0000_3040, 32'h0000_3024, 32'hC0DE_000D, 1, 0};
    vecs[16] = '{0, 0, 1, 2'd0, 16'h0004, 26'h0000000, 32'h0,        32'hC0DE_0010, 1, 32'h0000_3038, 32'h0000_3040, 32'hC0DE_0010, 1, 0};
    vecs[17] = '{0, 0, 0, 2'd2, 16'h0000, 26'h0000000, 32'h0000_3002, 32'hC0DE_0011, 1, 32'h0000_3002, 32'h0000_3038, 32'hC0DE_0011, 1, 0};
    vecs[18] = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0012, 0, 32'h0000_3006, 32'h0000_3002, 32'hC0DE_0012, 1, 1};
    vecs[19] = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0013, 0, 32'h0000_300A, 32'h0000_3006, 32'hC0DE_0013, 1, 1};
    vecs[20] = '{0, 0, 0, 2'd2, 16'h0000, 26'h0000000, 32'hFFFF_FFFC, 32'hC0DE_0014, 1, 32'hFFFF_FFFC, 32'h0000_300A, 32'hC0DE_0014, 1, 1};
    vecs[21] = '{0, 0, 0, 2'd0, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0015, 0, 32'h0000_0000, 32'hFFFF_FFFC, 32'hC0DE_0015, 1, 0};
    vecs[22] = '{0, 0, 1, 2'd0, 16'hFFFE, 26'h0000000, 32'h0,        32'hC0DE_0016, 1, 32'hFFFF_FFF8, 32'h0000_0000, 32'hC0DE_0016, 1, 0};
    vecs[23] = '{0, 0, 0, 2'd3, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0017, 0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hC0DE_0017, 1, 0};
    vecs[24] = '{0, 0, 1, 2'd3, 16'h0000, 26'h0000000, 32'h0,        32'hC0DE_0018, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hC0DE_0018, 1, 0};

    clear_inputs();
    reset = 1'b1;
    branch = 1'b1;
    #1;
    chk("rst pc",       pc,               32'h0000_3000);
    chk("rst id_pc",    id_pc,            32'h0000_3000);
    chk("rst id_instr", id_instr,         32'h0000_0000);
    chk("rst id_valid", 32'(id_valid),    32'd0);
    chk("rst id_adel",  32'(id_adel),     32'd0);
    chk("rst redirect", 32'(redirect),    32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) begin
        reset = 1'b1;
        #1;
        chk($sformatf("r%0d reset pc", i), pc, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b0;
      end
      stall    = vecs[i].stall;
      branch   = vecs[i].branch;
      jump_op  = vecs[i].jop;
      imm16    = vecs[i].imm16;
      imm26    = vecs[i].imm26;
      rs_value = vecs[i].rs;
      im_instr = vecs[i].im;
      #1;
      chk($sformatf("r%0d redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
      @(posedge clk);
      #1;
      chk($sformatf("r%0d pc", i),       pc,             vecs[i].e_pc);
      chk($sformatf("r%0d id_pc", i),    id_pc,          vecs[i].e_id_pc);
      chk($sformatf("r%0d id_instr", i), id_instr,       vecs[i].e_id_instr);
      chk($sformatf("r%0d id_valid", i), 32'(id_valid),  32'(vecs[i].e_valid));
      chk($sformatf("r%0d id_adel", i),  32'(id_adel),   32'(vecs[i].e_adel));
    end

    // reset arriving asynchronously while a stalled branch is pending
    clear_inputs();
    stall  = 1'b1;
    branch = 1'b1;
    imm16  = 16'h0020;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async pc",       pc,            32'h0000_3000);
    chk("async id_pc",    id_pc,         32'h0000_3000);
    chk("async id_instr", id_instr,      32'h0000_0000);
    chk("async id_valid", 32'(id_valid), 32'd0);
    chk("async redirect", 32'(redirect), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    stall    = 1'b0;
    im_instr = 32'hBEEF_0001;
    #1;
    chk("post redirect", 32'(redirect), 32'd0);
    @(posedge clk);
    #1;
    chk("post pc",       pc,            32'h0000_3004);
    chk("post id_pc",    id_pc,         32'h0000_3000);
    chk("post id_instr", id_instr,      32'hBEEF_0001);
    chk("post id_valid", 32'(id_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
